// File: rtl/enigma_step_ctrl.sv
// Enigma sequencing controller: owns rotor positions, steps them per keypress and
// walks one shared wiring lookup through the seven substitution stages.
module enigma_step_ctrl #(
   parameter logic [4:0] NOTCH1 = 5'd16,
   parameter logic [4:0] NOTCH2 = 5'd4,
   parameter logic [4:0] NOTCH3 = 5'd21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [4:0]  key_in,
   output logic        key_ready,
   input  logic        load_pos,
   input  logic [14:0] pos_init,
   output logic [14:0] pos,
   output logic [2:0]  lu_sel,
   output logic [4:0]  lu_in,
   output logic [4:0]  lu_rotate,
   input  logic [4:0]  lu_out,
   output logic        out_valid,
   output logic [4:0]  out_letter,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, STEP, PASS, DONE} state_t;

   if (NOTCH1 > 5'd25 || NOTCH2 > 5'd25 || NOTCH3 > 5'd25) begin : g_bad_notch
      $error("enigma_step_ctrl: notch parameters must be in 0..25");
   end

   function automatic logic [4:0] inc26(input logic [4:0] v);
      return (v == 5'd25) ? 5'd0 : v + 5'd1;
   endfunction

   state_t     state, state_nx;
   logic [4:0] r1, r2, r3, letter;
   logic [4:0] r1_s, r2_s, r3_s, rot_nx;
   logic [2:0] stage_nx;
   logic       key_ok, init_ok;
   logic       accept, load_ok, load_bad, key_bad, abort, finish;

   assign pos       = {r3, r2, r1};
   assign busy      = (state != IDLE);
   assign key_ready = (state == IDLE) & ~load_pos & ~rst;
   assign key_ok    = (key_in != 5'd0) && (key_in <= 5'd26);
   assign init_ok   = (pos_init[4:0] <= 5'd25) && (pos_init[9:5] <= 5'd25) &&
                      (pos_init[14:10] <= 5'd25);

   // Double-step falls out of R2 also stepping on its own notch.
   assign r1_s = inc26(r1);
   assign r2_s = (r1 == NOTCH1 || r2 == NOTCH2) ? inc26(r2) : r2;
   assign r3_s = (r2 == NOTCH2) ? inc26(r3) : r3;

   // lu_sel doubles as the stage counter during PASS.
   assign stage_nx = lu_sel + 3'd1;
   always_comb begin
      rot_nx = 5'd0;
      case (stage_nx)
         3'd0, 3'd6: rot_nx = r1;
         3'd1, 3'd5: rot_nx = r2;
         3'd2, 3'd4: rot_nx = r3;
         default:    rot_nx = 5'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      load_ok  = 1'b0;
      load_bad = 1'b0;
      key_bad  = 1'b0;
      abort    = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (load_pos) begin
               load_ok  = init_ok;
               load_bad = ~init_ok;
            end else if (key_valid) begin
               if (key_ok) begin
                  accept   = 1'b1;
                  state_nx = STEP;
               end else begin
                  key_bad = 1'b1;
               end
            end
         end
         STEP: state_nx = PASS;
         PASS: begin
            if (lu_out == 5'd0) begin
               abort    = 1'b1;
               state_nx = IDLE;
            end else if (lu_sel == 3'd6) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r1         <= 5'd0;
         r2         <= 5'd0;
         r3         <= 5'd0;
         letter     <= 5'd0;
         lu_sel     <= 3'd0;
         lu_in      <= 5'd0;
         lu_rotate  <= 5'd0;
         out_valid  <= 1'b0;
         out_letter <= 5'd0;
         err        <= 1'b0;
      end else begin
         err       <= load_bad | key_bad | abort;
         out_valid <= finish;
         if (load_ok) {r3, r2, r1} <= pos_init;
         if (accept)  letter <= key_in;
         if (state == STEP) begin
            {r3, r2, r1} <= {r3_s, r2_s, r1_s};
            lu_sel       <= 3'd0;
            lu_in        <= letter;
            lu_rotate    <= r1_s;
         end
         if (state == PASS && !abort && !finish) begin
            lu_sel    <= stage_nx;
            lu_in     <= lu_out;
            lu_rotate <= rot_nx;
         end
         if (finish) out_letter <= lu_out;
      end
   end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Self-checking bench for enigma_step_ctrl: rotor stepping, stage sequencing,
// error pulses and reset abort against an arithmetic reference model.
module tb_enigma_step_ctrl;

   logic        clk = 1'b0;
   logic        rst, key_valid, load_pos;
   logic [4:0]  key_in;
   logic [14:0] pos_init;
   logic        key_ready, out_valid, err, busy;
   logic [14:0] pos;
   logic [2:0]  lu_sel;
   logic [4:0]  lu_in, lu_rotate, lu_out, out_letter;
   logic        key_ready_w, out_valid_w, err_w, busy_w;
   logic [14:0] pos_w;
   logic [2:0]  lu_sel_w;
   logic [4:0]  lu_in_w, lu_rotate_w, lu_out_w, out_letter_w;

   int n_chk = 0, n_fail = 0;
   int mode = 0, salt = 0, zero_stage = -1;
   int m1 = 0, m2 = 0, m3 = 0;

   always #5 clk = ~clk;

   enigma_step_ctrl dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
      .load_pos(load_pos), .pos_init(pos_init), .pos(pos), .lu_sel(lu_sel), .lu_in(lu_in),
      .lu_rotate(lu_rotate), .lu_out(lu_out), .out_valid(out_valid), .out_letter(out_letter),
      .err(err), .busy(busy));

   enigma_step_ctrl #(.NOTCH1(5'd25), .NOTCH2(5'd25), .NOTCH3(5'd21)) dut_w (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready_w),
      .load_pos(load_pos), .pos_init(pos_init), .pos(pos_w), .lu_sel(lu_sel_w), .lu_in(lu_in_w),
      .lu_rotate(lu_rotate_w), .lu_out(lu_out_w), .out_valid(out_valid_w),
      .out_letter(out_letter_w), .err(err_w), .busy(busy_w));

   // Lookup model: identity or an arbitrary non-zero scramble; one stage can be forced to 0.
   function automatic logic [4:0] lk(int md, int sl, int zs, int s, int x, int rot);
      if (s == zs) return 5'd0;
      if (md == 0) return 5'(x);
      return 5'(((x + 25 + rot * 3 + s * 5 + sl) % 26) + 1);
   endfunction

   always_comb lu_out   = lk(mode, salt, zero_stage, int'(lu_sel), int'(lu_in), int'(lu_rotate));
   always_comb lu_out_w = lu_in_w;

   function automatic int stage_rot(int s);
      if (s == 0 || s == 6) return m1;
      if (s == 1 || s == 5) return m2;
      if (s == 3) return 0;
      return m3;
   endfunction

   function automatic logic [14:0] mpos();
      return {5'(m3), 5'(m2), 5'(m1)};
   endfunction

   // Odometer rule on pre-step positions, notches 16 / 4.
   task automatic model_step();
      bit c2, c3;
      c2 = (m1 == 16) || (m2 == 4);
      c3 = (m2 == 4);
      m1 = (m1 + 1) % 26;
      if (c2) m2 = (m2 + 1) % 26;
      if (c3) m3 = (m3 + 1) % 26;
   endtask

   function automatic logic [4:0] encrypt(int letter);
      int x = letter;
      for (int s = 0; s < 7; s++) x = int'(lk(mode, salt, -1, s, x, stage_rot(s)));
      return 5'(x);
   endfunction

   task automatic do_load(input logic [14:0] v);
      load_pos = 1'b1; pos_init = v;
      @(negedge clk);
      load_pos = 1'b0;
      m1 = int'(v[4:0]); m2 = int'(v[9:5]); m3 = int'(v[14:10]);
      #1;
   endtask

   // Drive one key from IDLE and check the whole 10-cycle letter.
   task automatic run_letter(input logic [4:0] letter);
      logic [4:0] exp;
      key_valid = 1'b1; key_in = letter; #1;
      n_chk++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL key_ready_idle got %b want 1", key_ready); end
      @(negedge clk); key_valid = 1'b0; #1;
      n_chk++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL step_busy got busy=%b ov=%b want 1/0", busy, out_valid); end
      model_step();
      exp = encrypt(int'(letter));
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); #1;
         n_chk++; if (lu_sel !== 3'(k)) begin n_fail++; $display("FAIL lu_sel k=%0d got %0d want %0d", k, lu_sel, k); end
         n_chk++; if (lu_rotate !== 5'(stage_rot(k))) begin n_fail++; $display("FAIL lu_rotate k=%0d got %0d want %0d", k, lu_rotate, stage_rot(k)); end
         if (k == 0) begin
            n_chk++; if (lu_in !== letter) begin n_fail++; $display("FAIL lu_in0 got %0d want %0d", lu_in, letter); end
            n_chk++; if (pos !== mpos()) begin n_fail++; $display("FAIL pos_step got %h want %h", pos, mpos()); end
         end
      end
      @(negedge clk); #1;
      n_chk++; if (out_valid !== 1'b1 || out_letter !== exp || err !== 1'b0) begin
         n_fail++; $display("FAIL done got ov=%b letter=%0d err=%b want 1/%0d/0", out_valid, out_letter, err, exp); end
      @(negedge clk); #1;
      n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_letter !== exp) begin
         n_fail++; $display("FAIL after_done got ov=%b busy=%b letter=%0d want 0/0/%0d", out_valid, busy, out_letter, exp); end
   endtask

   task automatic test_reset();
      rst = 1'b1; key_valid = 1'b0; key_in = 5'd0; load_pos = 1'b0; pos_init = 15'd0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_rst got %b want 0", key_ready); end
      rst = 1'b0; #1;
      n_chk++; if (pos !== 15'd0 || out_letter !== 5'd0 || out_valid !== 1'b0 || err !== 1'b0 ||
                   lu_sel !== 3'd0 || lu_in !== 5'd0 || lu_rotate !== 5'd0 || busy !== 1'b0 || key_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_state got pos=%h ol=%0d ov=%b err=%b sel=%0d in=%0d rot=%0d busy=%b rdy=%b want zeros/rdy=1",
                            pos, out_letter, out_valid, err, lu_sel, lu_in, lu_rotate, busy, key_ready); end
      m1 = 0; m2 = 0; m3 = 0;
   endtask

   task automatic test_identity();
      mode = 0;
      run_letter(5'd1);
      n_chk++; if (pos !== {5'd0, 5'd0, 5'd1}) begin n_fail++; $display("FAIL identity_pos got %h want 0001", pos); end
   endtask

   task automatic test_double_step();
      mode = 0;
      do_load({5'd0, 5'd3, 5'd16});
      run_letter(5'd9);
      n_chk++; if (pos !== {5'd0, 5'd4, 5'd17}) begin n_fail++; $display("FAIL dstep1 got %h want %h", pos, {5'd0, 5'd4, 5'd17}); end
      run_letter(5'd26);
      n_chk++; if (pos !== {5'd1, 5'd5, 5'd18}) begin n_fail++; $display("FAIL dstep2 got %h want %h", pos, {5'd1, 5'd5, 5'd18}); end
   endtask

   task automatic test_wrap();
      mode = 0;
      do_load({5'd25, 5'd25, 5'd25});
      run_letter(5'd13);
      n_chk++; if (pos_w !== 15'd0) begin n_fail++; $display("FAIL full_wrap got %h want 0000", pos_w); end
      n_chk++; if (pos !== {5'd25, 5'd25, 5'd0}) begin n_fail++; $display("FAIL r1_wrap got %h want %h", pos, {5'd25, 5'd25, 5'd0}); end
   endtask

   task automatic test_bad_input();
      logic [4:0] bad [3] = '{5'd0, 5'd27, 5'd31};
      logic [14:0] p0;
      p0 = pos;
      foreach (bad[i]) begin
         key_valid = 1'b1; key_in = bad[i];
         @(negedge clk); key_valid = 1'b0; #1;
         n_chk++; if (err !== 1'b1 || busy !== 1'b0 || pos !== p0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bad_key %0d got err=%b busy=%b pos=%h want 1/0/%h", bad[i], err, busy, pos, p0); end
         @(negedge clk); #1;
         n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse got %b want 0", err); end
      end
      load_pos = 1'b1; pos_init = {5'd2, 5'd26, 5'd3};
      @(negedge clk); load_pos = 1'b0; #1;
      n_chk++; if (err !== 1'b1 || pos !== p0) begin n_fail++; $display("FAIL bad_init got err=%b pos=%h want 1/%h", err, pos, p0); end
   endtask

   task automatic test_back_to_back();
      int acc = 0, at = 0, t = 0;
      mode = 0;
      key_valid = 1'b1; key_in = 5'd7;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk); #1;
         if (key_valid && key_ready) begin acc++; at = i; end
      end
      n_chk++; if (acc != 1 || at != 10) begin n_fail++; $display("FAIL held_accept got count=%0d at=%0d want 1/10", acc, at); end
      model_step(); model_step();
      @(negedge clk); key_valid = 1'b0; #1;
      while (busy === 1'b1 && t < 30) begin @(negedge clk); #1; t++; end
      n_chk++; if (busy !== 1'b0 || pos !== mpos()) begin n_fail++; $display("FAIL held_pos got busy=%b pos=%h want 0/%h", busy, pos, mpos()); end
   endtask

   task automatic test_lookup_zero();
      int ov = 0;
      mode = 1; salt = 11; zero_stage = 3;
      key_valid = 1'b1; key_in = 5'd20;
      @(negedge clk); key_valid = 1'b0;
      model_step();
      for (int i = 1; i <= 5; i++) begin @(negedge clk); #1; ov += int'(out_valid); end
      n_chk++; if (err !== 1'b1 || busy !== 1'b0 || ov != 0) begin
         n_fail++; $display("FAIL lu_zero got err=%b busy=%b ov_count=%0d want 1/0/0", err, busy, ov); end
      n_chk++; if (pos !== mpos()) begin n_fail++; $display("FAIL lu_zero_pos got %h want %h", pos, mpos()); end
      @(negedge clk); #1;
      n_chk++; if (err !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_zero_after got err=%b ov=%b want 0/0", err, out_valid); end
      zero_stage = -1;
   endtask

   task automatic test_load_priority();
      load_pos = 1'b1; key_valid = 1'b1; key_in = 5'd4; pos_init = {5'd6, 5'd7, 5'd8}; #1;
      n_chk++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got %b want 0", key_ready); end
      @(negedge clk); load_pos = 1'b0; key_valid = 1'b0; #1;
      m1 = 8; m2 = 7; m3 = 6;
      n_chk++; if (pos !== mpos() || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL load_prio got pos=%h busy=%b err=%b want %h/0/0", pos, busy, err, mpos()); end
   endtask

   task automatic test_reset_mid();
      int ov = 0;
      mode = 1; salt = 3;
      key_valid = 1'b1; key_in = 5'd3;
      @(negedge clk); key_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      n_chk++; if (pos !== 15'd0 || out_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || out_letter !== 5'd0 ||
                   lu_sel !== 3'd0 || lu_in !== 5'd0 || lu_rotate !== 5'd0) begin
         n_fail++; $display("FAIL rst_mid got pos=%h ov=%b err=%b busy=%b ol=%0d sel=%0d in=%0d rot=%0d want zeros",
                            pos, out_valid, err, busy, out_letter, lu_sel, lu_in, lu_rotate); end
      for (int i = 0; i < 8; i++) begin @(negedge clk); #1; ov += int'(out_valid); end
      n_chk++; if (ov != 0) begin n_fail++; $display("FAIL rst_mid_ov got %0d pulses want 0", ov); end
      m1 = 0; m2 = 0; m3 = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         mode = 1; salt = int'($urandom_range(0, 25));
         if ($urandom_range(0, 2) == 0)
            do_load({5'($urandom_range(0, 25)), 5'($urandom_range(3, 5)), 5'($urandom_range(15, 17))});
         else if ($urandom_range(0, 3) == 0)
            do_load({5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))});
         run_letter(5'($urandom_range(1, 26)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_identity();
      test_double_step();
      test_wrap();
      test_bad_input();
      test_back_to_back();
      test_lookup_zero();
      test_load_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
